// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one signed MAC walks NTAPS taps per accepted sample,
// then rounds, saturates and pulses out_valid for one cycle.
module fir_mac_serial #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 8,
  parameter int NTAPS    = 8,
  parameter int ACC_W    = 32,
  parameter int SHIFT    = 0,
  parameter int OUT_W    = 32,
  parameter int COEF_RST = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat
);

  localparam int AW     = $clog2(NTAPS);
  localparam int PW     = DATA_W + COEF_W;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [COEF_W-1:0]    COEF_INIT = COEF_W'(COEF_RST);
  localparam logic signed [ACC_W:0] RND_ADD  =
      (SHIFT == 0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << RND_SH);
  localparam logic signed [ACC_W:0] OUT_MAX  = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN  = ~OUT_MAX;

  typedef enum logic {IDLE, MAC} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] d_q    [NTAPS];
  logic [DATA_W-1:0] d_d    [NTAPS];
  logic [COEF_W-1:0] coef_q [NTAPS];
  logic [COEF_W-1:0] coef_d [NTAPS];
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]     k_q, k_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;

  logic                     accept, last_tap, addr_ok;
  logic [COEF_W-1:0]        coef_sel;
  logic [DATA_W-1:0]        d_sel;
  logic [PW-1:0]            prod;
  logic [ACC_W-1:0]         sum;
  logic signed [ACC_W:0]    rnd_pre, rnd;
  logic [OUT_W-1:0]         sat_val;
  logic                     sat_flag;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (last_tap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) && !reset;
  end

  assign accept   = in_ready && in_valid;
  assign last_tap = (k_q == AW'(NTAPS - 1));
  assign addr_ok  = {1'b0, coef_addr} < (AW+1)'(NTAPS);
  assign coef_sel = coef_q[k_q];
  assign d_sel    = d_q[k_q];

  // Both operands sign-extended to the product width so the low PW bits are the exact signed product.
  assign prod    = {{DATA_W{coef_sel[COEF_W-1]}}, coef_sel} * {{COEF_W{d_sel[DATA_W-1]}}, d_sel};
  assign sum     = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign rnd_pre = $signed({sum[ACC_W-1], sum}) + RND_ADD;
  assign rnd     = rnd_pre >>> SHIFT;

  always_comb begin
    sat_val  = rnd[OUT_W-1:0];
    sat_flag = 1'b0;
    if (rnd > OUT_MAX) begin
      sat_val  = OUT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (rnd < OUT_MIN) begin
      sat_val  = OUT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    d_d         = d_q;
    coef_d      = coef_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    // A write on the accept edge lands before the first MAC cycle reads it.
    if (state_q == IDLE && coef_we && addr_ok) coef_d[coef_addr] = coef_wdata;
    if (accept) begin
      d_d[0] = in_data;
      for (int i = 1; i < NTAPS; i++) d_d[i] = d_q[i-1];
      acc_d = '0;
      k_d   = '0;
    end
    if (state_q == MAC) begin
      acc_d = sum;
      k_d   = k_q + AW'(1);
      if (last_tap) begin
        out_valid_d = 1'b1;
        out_data_d  = sat_val;
        out_sat_d   = sat_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        d_q[i]    <= '0;
        coef_q[i] <= COEF_INIT;
      end
    end else begin
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      d_q         <= d_d;
      coef_q      <= coef_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_mac_serial.sv
// Bench for fir_mac_serial: three parameter variants share one stimulus stream and are
// checked every cycle against a sum-of-products reference, plus literal result checks.
module tb_fir_mac_serial;
  localparam int NT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, coef_we, in_valid;
  logic [2:0]  coef_addr;
  logic [7:0]  coef_wdata;
  logic [15:0] in_data;
  logic        rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c, sat_a, sat_b, sat_c;
  logic [31:0] dat_a, dat_c;
  logic [15:0] dat_b;

  fir_mac_serial u_a (.clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .out_valid(vld_a), .out_data(dat_a), .out_sat(sat_a));
  fir_mac_serial #(.OUT_W(16)) u_b (.clk(clk), .reset(reset), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .out_valid(vld_b), .out_data(dat_b), .out_sat(sat_b));
  fir_mac_serial #(.SHIFT(4)) u_c (.clk(clk), .reset(reset), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(rdy_c),
    .in_data(in_data), .out_valid(vld_c), .out_data(dat_c), .out_sat(sat_c));

  // Reference state: sample history, coefficients, accept time and held results.
  int     cyc = 0;
  int     acc_edge = -1000;
  longint hist [NT];
  longint coefm [NT];
  longint pend [3];
  logic   pend_sat [3];
  longint exp_dat [3];
  logic   exp_sat [3];
  int     shift_p [3] = '{0, 0, 4};
  int     outw_p  [3] = '{32, 16, 32};

  int     n_vec = 0, n_bad = 0;
  longint res_a[$], res_b[$], res_c[$];
  logic   sb_q[$];
  int     acc_e[$];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic rnd_sat(input longint s, input int sh, input int ow, output longint r, output logic st);
    longint mx, mn;
    r = s;
    if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -(longint'(1) << (ow - 1));
    st = 1'b0;
    if (r > mx) begin r = mx; st = 1'b1; end
    else if (r < mn) begin r = mn; st = 1'b1; end
  endtask

  task automatic check();
    logic exp_rdy, exp_vld;
    exp_rdy = !reset && (cyc >= acc_edge + NT);
    exp_vld = (cyc == acc_edge + NT);
    chk("ready_a", rdy_a, exp_rdy);  chk("ready_b", rdy_b, exp_rdy);  chk("ready_c", rdy_c, exp_rdy);
    chk("valid_a", vld_a, exp_vld);  chk("valid_b", vld_b, exp_vld);  chk("valid_c", vld_c, exp_vld);
    chk("data_a", $signed(dat_a), exp_dat[0]);
    chk("data_b", $signed(dat_b), exp_dat[1]);
    chk("data_c", $signed(dat_c), exp_dat[2]);
    chk("sat_a", sat_a, exp_sat[0]);  chk("sat_b", sat_b, exp_sat[1]);  chk("sat_c", sat_c, exp_sat[2]);
    if (vld_a === 1'b1) res_a.push_back(longint'($signed(dat_a)));
    if (vld_b === 1'b1) begin res_b.push_back(longint'($signed(dat_b))); sb_q.push_back(sat_b); end
    if (vld_c === 1'b1) res_c.push_back(longint'($signed(dat_c)));
  endtask

  // Advance one clock: update the reference with the inputs now driven, then check.
  task automatic tick();
    logic   idle;
    longint s;
    idle = (cyc >= acc_edge + NT);
    if (rdy_a === 1'b1 && in_valid) acc_e.push_back(cyc + 1);
    if (reset) begin
      for (int i = 0; i < NT; i++) begin hist[i] = 0; coefm[i] = 16; end
      acc_edge = -1000;
      for (int j = 0; j < 3; j++) begin exp_dat[j] = 0; exp_sat[j] = 1'b0; end
    end else begin
      if (idle && coef_we) coefm[coef_addr] = longint'($signed(coef_wdata));
      if (idle && in_valid) begin
        for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = longint'($signed(in_data));
        s = 0;
        for (int i = 0; i < NT; i++) s += coefm[i] * hist[i];
        for (int j = 0; j < 3; j++) rnd_sat(s, shift_p[j], outw_p[j], pend[j], pend_sat[j]);
        acc_edge = cyc + 1;
      end
    end
    cyc++;
    if (cyc == acc_edge + NT)
      for (int j = 0; j < 3; j++) begin exp_dat[j] = pend[j]; exp_sat[j] = pend_sat[j]; end
    @(negedge clk);
    check();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [15:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_data  = x;
    do begin tick(); n++; end while (acc_edge != cyc && n < 30);
    if (acc_edge != cyc) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout @cyc %0d: sample %0d not taken within 30 cycles", cyc, x);
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = 3'(a);
    coef_wdata = 8'(v);
    tick();
    coef_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < NT; i++) begin hist[i] = 0; coefm[i] = 16; end
    for (int j = 0; j < 3; j++) begin pend[j] = 0; pend_sat[j] = 1'b0; exp_dat[j] = 0; exp_sat[j] = 1'b0; end
    idle_n(2);
    reset = 1'b0;
    idle_n(2);

    // Impulse with default coefficients
    res_a.delete();
    send(16'd100);
    for (int i = 0; i < 8; i++) send(16'd0);
    idle_n(NT + 2);
    chk("t1_count", res_a.size(), 9);
    for (int i = 0; i < 9; i++) chk("t1_result", res_a[i], (i < 8) ? 1600 : 0);
    chk("t1_sat", sat_a, 0);

    // Step response
    res_a.delete();
    for (int i = 0; i < 9; i++) send(16'd1000);
    idle_n(NT + 2);
    for (int i = 0; i < 9; i++) chk("t2_result", res_a[i], (i < 8) ? 16000 * (i + 1) : 128000);

    // Ramp coefficients, impulse of 1
    for (int i = 0; i < NT; i++) wcoef(i, i + 1);
    for (int i = 0; i < 8; i++) send(16'd0);
    idle_n(NT + 2);
    res_a.delete();
    send(16'd1);
    for (int i = 0; i < 8; i++) send(16'd0);
    idle_n(NT + 2);
    for (int i = 0; i < 9; i++) chk("t3_result", res_a[i], (i < 8) ? i + 1 : 0);

    // Saturation on the 16-bit output variant
    for (int i = 0; i < NT; i++) wcoef(i, 127);
    res_b.delete(); sb_q.delete();
    for (int i = 0; i < 9; i++) send(16'd32767);
    idle_n(NT + 2);
    for (int i = 1; i < 9; i++) begin
      chk("t4_pos", res_b[i], 32767);
      chk("t4_pos_sat", sb_q[i], 1);
    end
    res_b.delete(); sb_q.delete();
    for (int i = 0; i < 9; i++) send(16'h8000);
    idle_n(NT + 2);
    chk("t4_neg", res_b[8], -32768);
    chk("t4_neg_sat", sb_q[8], 1);

    // Round-half-up on the SHIFT=4 variant
    wcoef(0, 1);
    for (int i = 1; i < NT; i++) wcoef(i, 0);
    res_a.delete(); res_c.delete();
    send(16'd24); send(-16'sd24); send(16'd8);
    idle_n(NT + 2);
    chk("t5_r24", res_c[0], 2);   chk("t5_rm24", res_c[1], -1);  chk("t5_r8", res_c[2], 1);
    chk("t5_raw24", res_a[0], 24); chk("t5_rawm24", res_a[1], -24);

    // Held in_valid: spacing of accepts, dropped coef write during MAC
    for (int i = 0; i < NT; i++) wcoef(i, 16);
    acc_e.delete(); res_a.delete();
    in_valid = 1'b1; in_data = 16'd500;
    for (int i = 0; i < 90; i++) begin
      coef_we = (i == 3); coef_addr = 3'd0; coef_wdata = 8'd99;
      tick();
    end
    coef_we = 1'b0; in_valid = 1'b0;
    idle_n(NT + 2);
    chk("t6_accepts", acc_e.size(), 10);
    for (int i = 0; i + 1 < acc_e.size(); i++) chk("t6_spacing", acc_e[i+1] - acc_e[i], NT + 1);
    chk("t6_steady", res_a[res_a.size() - 1], 64000);

    // Reset in the third MAC cycle aborts the result
    in_valid = 1'b1; in_data = 16'd100;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_rst_data", $signed(dat_a), 0);
    res_a.delete();
    idle_n(NT + 2);
    chk("t6_rst_nores", res_a.size(), 0);
    send(16'd100);
    for (int i = 0; i < 8; i++) send(16'd0);
    idle_n(NT + 2);
    chk("t6_post_first", res_a[0], 1600);
    chk("t6_post_last", res_a[7], 1600);
    chk("t6_post_zero", res_a[8], 0);

    // Random traffic, coefficient writes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 249) == 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      in_data    = 16'($urandom);
      coef_we    = ($urandom_range(0, 5) == 0);
      coef_addr  = 3'($urandom);
      coef_wdata = 8'($urandom);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
    idle_n(NT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
